// File: rtl/uart_cmd_parser.sv
// ASCII command parser behind the UART receiver: <letter><digits><CR|LF> sets the
// NCO tuning word, audio gain or demod mode and answers each command with ack or err.
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CLKS  = 13600000,
   parameter logic [31:0] DEF_FREQ_WORD = 32'd0,
   parameter logic [7:0]  DEF_GAIN      = 8'd128
) (
   input  logic        osc_clk,
   input  logic        rst_n,
   input  logic        i_Rx_DV,
   input  logic [7:0]  i_Rx_Byte,
   output logic [31:0] o_Freq_Word,
   output logic        o_Freq_Stb,
   output logic [7:0]  o_Gain,
   output logic [1:0]  o_Mode,
   output logic        o_Ack,
   output logic        o_Err
);

   localparam int unsigned   TW     = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

   typedef enum logic       {IDLE, VALUE} state_t;
   typedef enum logic [1:0] {CMD_F, CMD_G, CMD_M} cmd_t;

   state_t        state;
   cmd_t          cmd;
   logic [31:0]   acc;
   logic [3:0]    ndig;
   logic          ovf;
   logic [TW-1:0] tcnt;

   logic [35:0]   acc_next;
   logic [7:0]    lc;
   logic          is_digit;
   logic          is_term;
   logic          is_cmd;

   // acc*10 + d without a multiplier; the top nibble exposes 32-bit overflow
   assign acc_next = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + {32'd0, i_Rx_Byte[3:0]};
   assign lc       = i_Rx_Byte | 8'h20;
   assign is_digit = (i_Rx_Byte >= 8'h30) && (i_Rx_Byte <= 8'h39);
   assign is_term  = (i_Rx_Byte == 8'h0D) || (i_Rx_Byte == 8'h0A);
   assign is_cmd   = (lc == 8'h66) || (lc == 8'h67) || (lc == 8'h6D);

   // NOTE: all state and outputs are assigned with <= so every branch sees pre-edge values.
   always_ff @(posedge osc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cmd         <= CMD_F;
         acc         <= '0;
         ndig        <= '0;
         ovf         <= 1'b0;
         tcnt        <= '0;
         o_Freq_Word <= DEF_FREQ_WORD;
         o_Freq_Stb  <= 1'b0;
         o_Gain      <= DEF_GAIN;
         o_Mode      <= 2'd0;
         o_Ack       <= 1'b0;
         o_Err       <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle so each event yields exactly one pulse.
         o_Freq_Stb <= 1'b0;
         o_Ack      <= 1'b0;
         o_Err      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (i_Rx_DV) begin
                  if (is_cmd) begin
                     cmd   <= (lc == 8'h66) ? CMD_F : (lc == 8'h67) ? CMD_G : CMD_M;
                     acc   <= '0;
                     ndig  <= '0;
                     ovf   <= 1'b0;
                     tcnt  <= '0;
                     state <= VALUE;
                  end else if (!is_term && i_Rx_Byte != 8'h20) begin
                     o_Err <= 1'b1;
                  end
               end
            end
            VALUE: begin
               if (i_Rx_DV) begin
                  tcnt <= '0;
                  if (is_digit) begin
                     acc <= acc_next[31:0];
                     if (|acc_next[35:32]) ovf <= 1'b1;
                     if (ndig != 4'd15) ndig <= ndig + 4'd1;
                  end else if (is_term) begin
                     state <= IDLE;
                     if (ndig == 4'd0 || ovf) begin
                        o_Err <= 1'b1;
                     end else begin
                        case (cmd)
                           CMD_F: begin
                              o_Freq_Word <= acc;
                              o_Freq_Stb  <= 1'b1;
                              o_Ack       <= 1'b1;
                           end
                           CMD_G: begin
                              if (acc > 32'd255) o_Err <= 1'b1;
                              else begin
                                 o_Gain <= acc[7:0];
                                 o_Ack  <= 1'b1;
                              end
                           end
                           CMD_M: begin
                              if (acc > 32'd3) o_Err <= 1'b1;
                              else begin
                                 o_Mode <= acc[1:0];
                                 o_Ack  <= 1'b1;
                              end
                           end
                           default: o_Err <= 1'b1;
                        endcase
                     end
                  end else begin
                     o_Err <= 1'b1;
                     state <= IDLE;
                  end
               end else if (tcnt == T_LAST) begin
                  o_Err <= 1'b1;
                  state <= IDLE;
                  tcnt  <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
